// File: rtl/bin_search_ctrl.sv
// Window-narrowing search controller: binary steps on wide windows, linear steps
// once the window is narrow. The external scanner grades one trial bin at a time.
module bin_search_ctrl #(
    parameter  int BIN_W    = 10,
    parameter  int LIN_THR  = 10,
    parameter  int MAX_ITER = 32,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BIN_W-1:0]  center,
    input  logic [BIN_W-1:0]  range,
    input  logic              scan_done,
    input  logic              pass,
    output logic [BIN_W-1:0]  trial,
    output logic              trial_valid,
    output logic [BIN_W-1:0]  hibin,
    output logic [BIN_W-1:0]  lobin,
    output logic [BIN_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FAIL} state_t;

    localparam logic [BIN_W-1:0]  LIN_THR_W  = BIN_W'(LIN_THR);
    localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  lo_q, lo_d, hi_q, hi_d;
    logic [BIN_W-1:0]  trial_q, trial_d, result_q, result_d;
    logic [ITER_W-1:0] iter_q, iter_d;

    logic [BIN_W:0]    hi_sum;
    logic [BIN_W-1:0]  lo_load, hi_load, span, trial_calc, new_hi, new_lo;
    logic [ITER_W-1:0] iter_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            trial_q  <= '0;
            result_q <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            iter_q   <= iter_d;
        end
    end

    always_comb begin
        // Upper bound is summed one bit wider so it can saturate at the top code.
        hi_sum     = {1'b0, center} + {1'b0, range};
        hi_load    = hi_sum[BIN_W] ? '1 : hi_sum[BIN_W-1:0];
        lo_load    = (center < range) ? '0 : center - range;
        span       = hi_q - lo_q;
        trial_calc = (span <= LIN_THR_W) ? hi_q - 1'b1 : lo_q + (span >> 1);
        new_hi     = pass ? trial_q : hi_q;
        new_lo     = pass ? lo_q : trial_q + 1'b1;
        iter_inc   = iter_q + 1'b1;

        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        trial_d  = trial_q;
        result_d = result_q;
        iter_d   = iter_q;

        if (start) begin
            lo_d    = lo_load;
            hi_d    = hi_load;
            iter_d  = '0;
            state_d = S_ISSUE;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (hi_q == lo_q) begin
                        result_d = hi_q;
                        state_d  = S_DONE;
                    end else begin
                        trial_d = trial_calc;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (scan_done) begin
                        hi_d   = new_hi;
                        lo_d   = new_lo;
                        iter_d = iter_inc;
                        if (iter_inc == MAX_ITER_W && new_hi != new_lo) begin
                            result_d = new_hi;
                            state_d  = S_FAIL;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign trial       = trial_q;
    assign trial_valid = (state_q == S_WAIT);
    assign hibin       = hi_q;
    assign lobin       = lo_q;
    assign result      = result_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign fail        = (state_q == S_FAIL);
    assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Scoreboarded bench: expected trial sequences are queued at start and popped as
// each trial is offered; a second instance with a small trial limit covers FAIL.
module tb_bin_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] center = '0;
    logic [9:0] range = '0;
    logic       scan_done = 1'b0;
    logic       pass = 1'b0;
    logic       sel = 1'b0;

    logic [9:0] a_trial, a_hi, a_lo, a_result;
    logic       a_tv, a_busy, a_done, a_fail;
    logic [5:0] a_iter;
    logic [9:0] b_trial, b_hi, b_lo, b_result;
    logic       b_tv, b_busy, b_done, b_fail;
    logic [2:0] b_iter;

    logic [9:0] m_trial, m_hi, m_lo, m_result;
    logic       m_tv, m_busy, m_done, m_fail;
    logic [5:0] m_iter;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    bin_search_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .center(center), .range(range),
        .scan_done(scan_done), .pass(pass), .trial(a_trial), .trial_valid(a_tv),
        .hibin(a_hi), .lobin(a_lo), .result(a_result), .busy(a_busy),
        .done(a_done), .fail(a_fail), .iter_cnt(a_iter)
    );

    bin_search_ctrl #(.MAX_ITER(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .center(center), .range(range),
        .scan_done(scan_done), .pass(pass), .trial(b_trial), .trial_valid(b_tv),
        .hibin(b_hi), .lobin(b_lo), .result(b_result), .busy(b_busy),
        .done(b_done), .fail(b_fail), .iter_cnt(b_iter)
    );

    assign m_trial  = sel ? b_trial  : a_trial;
    assign m_hi     = sel ? b_hi     : a_hi;
    assign m_lo     = sel ? b_lo     : a_lo;
    assign m_result = sel ? b_result : a_result;
    assign m_tv     = sel ? b_tv     : a_tv;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_done   = sel ? b_done   : a_done;
    assign m_fail   = sel ? b_fail   : a_fail;
    assign m_iter   = sel ? {3'b000, b_iter} : a_iter;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_search(input int c, input int r);
        start  = 1'b1;
        center = 10'(c);
        range  = 10'(r);
        tick();
        start  = 1'b0;
        $display("[TB] start center=%0d range=%0d lo=%0d hi=%0d", c, r, m_lo, m_hi);
    endtask

    // Answers each offered trial with pass = (trial >= thr) until DONE/FAIL.
    task automatic run_search(input int thr);
        int exp_t;
        int budget;
        budget = 200;
        while (!m_done && !m_fail && budget > 0) begin
            budget--;
            if (m_tv) begin
                if (exp_q.size() == 0) begin
                    chk("extra_trial", 32'(m_trial), 32'hFFFF_FFFF);
                    exp_t = -1;
                end else begin
                    exp_t = exp_q.pop_front();
                    chk("trial", 32'(m_trial), 32'(exp_t));
                end
                pass      = (int'(m_trial) >= thr);
                scan_done = 1'b1;
                $display("[TB] trial=%0d expected=%0d pass=%0d", m_trial, exp_t, pass);
                tick();
                scan_done = 1'b0;
                pass      = 1'b0;
            end else begin
                tick();
            end
        end
        chk("search_timeout", 32'(budget == 0), 32'd0);
        chk("trials_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_hi", 32'(a_hi), 0);
        chk("rst_lo", 32'(a_lo), 0);
        chk("rst_trial", 32'(a_trial), 0);
        chk("rst_result", 32'(a_result), 0);
        chk("rst_flags", {28'd0, a_tv, a_busy, a_done, a_fail}, 0);
        chk("rst_iter", 32'(a_iter), 0);
        #20;
        rst_n = 1'b1;
        tick();

        // Converging search through binary then linear phase
        sel = 1'b0;
        start_search(100, 20);
        chk("s1_lo", 32'(m_lo), 80);
        chk("s1_hi", 32'(m_hi), 120);
        chk("s1_busy", 32'(m_busy), 1);
        exp_q = '{100, 90, 99, 98, 97, 96, 95, 94, 93, 92};
        run_search(93);
        chk("s1_done", 32'(m_done), 1);
        chk("s1_fail", 32'(m_fail), 0);
        chk("s1_result", 32'(m_result), 93);
        chk("s1_iter", 32'(m_iter), 10);
        chk("s1_busy_end", 32'(m_busy), 0);
        scan_done = 1'b1;
        pass      = 1'b1;
        tick();
        scan_done = 1'b0;
        pass      = 1'b0;
        tick();
        chk("s1_frozen_result", 32'(m_result), 93);
        chk("s1_frozen_iter", 32'(m_iter), 10);
        chk("s1_frozen_done", 32'(m_done), 1);

        // Low end clamps at zero
        start_search(5, 20);
        chk("s2_lo", 32'(m_lo), 0);
        chk("s2_hi", 32'(m_hi), 25);
        tick();
        chk("s2_tv", 32'(m_tv), 1);
        chk("s2_trial", 32'(m_trial), 12);

        // Zero range: DONE two edges after start, no trial offered
        start_search(300, 0);
        chk("s3_tv_issue", 32'(m_tv), 0);
        chk("s3_done_issue", 32'(m_done), 0);
        tick();
        chk("s3_done", 32'(m_done), 1);
        chk("s3_result", 32'(m_result), 300);
        chk("s3_iter", 32'(m_iter), 0);
        chk("s3_tv", 32'(m_tv), 0);

        // Trial limit reached before convergence (limited instance)
        sel = 1'b1;
        start_search(500, 500);
        chk("s4_lo", 32'(m_lo), 0);
        chk("s4_hi", 32'(m_hi), 1000);
        exp_q = '{500, 250, 125, 62};
        run_search(0);
        chk("s4_fail", 32'(m_fail), 1);
        chk("s4_done", 32'(m_done), 0);
        chk("s4_result", 32'(m_result), 62);
        chk("s4_iter", 32'(m_iter), 4);

        // Saturated top, then restart colliding with scan_done
        sel = 1'b0;
        start_search(1020, 10);
        chk("s5_hi", 32'(m_hi), 1023);
        chk("s5_lo", 32'(m_lo), 1010);
        tick();
        chk("s5_tv", 32'(m_tv), 1);
        chk("s5_trial", 32'(m_trial), 1016);
        scan_done = 1'b1;
        pass      = 1'b1;
        start_search(200, 3);
        scan_done = 1'b0;
        pass      = 1'b0;
        chk("s5_new_lo", 32'(m_lo), 197);
        chk("s5_new_hi", 32'(m_hi), 203);
        chk("s5_new_iter", 32'(m_iter), 0);
        chk("s5_new_tv", 32'(m_tv), 0);
        tick();
        chk("s5_new_trial", 32'(m_trial), 202);
        chk("s5_new_tv_wait", 32'(m_tv), 1);

        // Asynchronous reset while waiting on a scan
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_tv", 32'(m_tv), 0);
        chk("s6_busy", 32'(m_busy), 0);
        chk("s6_hi", 32'(m_hi), 0);
        chk("s6_trial", 32'(m_trial), 0);
        #10;
        rst_n = 1'b1;
        tick();
        scan_done = 1'b1;
        pass      = 1'b1;
        tick();
        scan_done = 1'b0;
        pass      = 1'b0;
        tick();
        chk("s6_post_busy", 32'(m_busy), 0);
        chk("s6_post_tv", 32'(m_tv), 0);
        chk("s6_post_hi", 32'(m_hi), 0);
        chk("s6_post_iter", 32'(m_iter), 0);
        chk("s6_post_done", 32'(m_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
